// File: rtl/mmio_bus_pkg.sv
// mmio_bus_pkg: shared types and constants for the mmio_bus CPU-side bus
// bridge and its SRAM half-word phy.
package mmio_bus_pkg;

  // Width of the address region field, addr[31:20].
  localparam int REGION_W = 12;

  // Width of the per-phase SRAM wait-state counter (SRAM_WAIT is 0..7).
  localparam int PHASE_CNT_W = 3;

  // Read data returned with an error response.
  localparam logic [31:0] ERR_RDATA = 32'h0;

  typedef enum logic [2:0] {
    IDLE,
    SRAM_LO,
    SRAM_HI,
    PERIPH,
    RESP
  } state_t;

endpackage

// File: rtl/sram16_phy.sv
// sram16_phy: drives one 16-bit asynchronous SRAM half-word phase.
//
// Ports:
//   sck, rst_n   clock, asynchronous active-low reset
//   start        phase active; held high for the whole phase
//   half         0 = low half-word, 1 = high half-word (address lsb)
//   rw           1 = write, 0 = read
//   be[1:0]      byte enables for this half-word (write only)
//   wdat[15:0]   write data for this half-word
//   word_addr    32-bit word address, addr[19:2]
//   rdat[15:0]   SRAM data bus as seen by the bridge
//   done         last cycle of the phase
//   sram_*       SRAM pins; sram_data is driven only while writing
module sram16_phy
  import mmio_bus_pkg::*;
#(
  parameter int WAIT = 0
) (
  input  logic        sck,
  input  logic        rst_n,
  input  logic        start,
  input  logic        half,
  input  logic        rw,
  input  logic [1:0]  be,
  input  logic [15:0] wdat,
  input  logic [17:0] word_addr,
  output logic [15:0] rdat,
  output logic        done,
  output logic [18:0] sram_addr,
  inout  wire  [15:0] sram_data,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  output logic        sram_ub_n,
  output logic        sram_lb_n
);

  localparam logic [PHASE_CNT_W-1:0] LAST_CNT = PHASE_CNT_W'(WAIT);
  // With no wait states the write strobe still needs one full cycle.
  localparam logic [PHASE_CNT_W-1:0] WE_LEN = PHASE_CNT_W'((WAIT == 0) ? 1 : WAIT);

  logic [PHASE_CNT_W-1:0] cnt;
  logic                   drive;

  // Clearing on done (not only when start drops) lets the high phase
  // begin at zero when it follows the low phase back-to-back.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge sck or negedge rst_n) begin
    if (!rst_n)               cnt <= '0;
    else if (!start || done)  cnt <= '0;
    else                      cnt <= cnt + 1'b1;
  end

  assign done  = start && (cnt == LAST_CNT);
  assign drive = start && rw;

  // Pins decode straight from the phase inputs, which come from
  // async-reset flops, so reset releases the SRAM immediately.
  assign sram_addr = {word_addr, half};
  assign sram_ce_n = !start;
  assign sram_oe_n = !(start && !rw);
  assign sram_we_n = !(drive && (cnt < WE_LEN));
  assign sram_lb_n = !(start && (!rw || be[0]));
  assign sram_ub_n = !(start && (!rw || be[1]));
  assign sram_data = drive ? wdat : 16'bz;
  assign rdat      = sram_data;

endmodule

// File: rtl/mmio_bus.sv
// mmio_bus: single-master CPU bus bridge. Decodes addr[31:20] into a
// 16-bit async SRAM window (two half-word phases per access) and NSLV
// peripheral channels (cs/ack handshake with timeout). Each access ends
// with a one-cycle ready pulse qualified by err.
//
// Ports:
//   sck, rst_n            clock, asynchronous active-low reset
//   en, rw, sel, addr,    CPU request (en sampled only in IDLE)
//   wdata
//   rdata, ready, err     CPU response (rdata/err valid with ready)
//   sram_*                16-bit async SRAM pins
//   s_cs_n                per-channel select, active-low
//   s_rw, s_sel, s_addr,  latched request, shared by all channels
//   s_wdata
//   s_rdata, s_ack        per-channel read data (32 bits each) and ack
module mmio_bus
  import mmio_bus_pkg::*;
#(
  parameter int                  NSLV        = 4,
  parameter logic [REGION_W-1:0] DRAM_REGION = 12'h001,
  parameter logic [REGION_W-1:0] PERIPH_BASE = 12'h002,
  parameter int                  SRAM_WAIT   = 0,
  parameter int                  TIMEOUT     = 255
) (
  input  logic                sck,
  input  logic                rst_n,
  input  logic                en,
  input  logic                rw,
  input  logic [3:0]          sel,
  input  logic [31:0]         addr,
  input  logic [31:0]         wdata,
  output logic [31:0]         rdata,
  output logic                ready,
  output logic                err,
  output logic [18:0]         sram_addr,
  inout  wire  [15:0]         sram_data,
  output logic                sram_ce_n,
  output logic                sram_oe_n,
  output logic                sram_we_n,
  output logic                sram_ub_n,
  output logic                sram_lb_n,
  output logic [NSLV-1:0]     s_cs_n,
  output logic                s_rw,
  output logic [3:0]          s_sel,
  output logic [19:0]         s_addr,
  output logic [31:0]         s_wdata,
  input  logic [32*NSLV-1:0]  s_rdata,
  input  logic [NSLV-1:0]     s_ack
);

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_t      state, state_nx;
  logic        rw_q;
  logic [3:0]  sel_q;
  logic [19:0] addr_q;
  logic [31:0] wdata_q;
  logic [2:0]  ch_q;
  logic [15:0] per_cnt;

  // Region decode of the incoming request. The extra top bit of ch_off
  // flags regions below PERIPH_BASE.
  logic [REGION_W-1:0] region;
  logic [REGION_W:0]   ch_off;
  logic                hit_sram, hit_periph;

  assign region     = addr[31:20];
  assign ch_off     = {1'b0, region} - {1'b0, PERIPH_BASE};
  assign hit_sram   = (region == DRAM_REGION);
  assign hit_periph = !ch_off[REGION_W] && (ch_off < (REGION_W+1)'(NSLV));

  // Selected channel: only its ack and data are ever looked at.
  logic [NSLV-1:0] cs_mask;
  logic            ack_hit;
  logic [31:0]     ch_rdata;

  assign cs_mask = NSLV'(1) << ch_q;
  assign ack_hit = |(s_ack & cs_mask);

  // NOTE: every always_comb output gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    ch_rdata = '0;
    for (int i = 0; i < NSLV; i++)
      if (ch_q == 3'(i)) ch_rdata = s_rdata[32*i +: 32];
  end

  // SRAM phy hookup.
  logic        phy_start, phy_half, phy_done;
  logic [1:0]  phy_be;
  logic [15:0] phy_wdat, phy_rdat;

  assign phy_be   = phy_half ? sel_q[3:2]      : sel_q[1:0];
  assign phy_wdat = phy_half ? wdata_q[31:16]  : wdata_q[15:0];

  sram16_phy #(.WAIT(SRAM_WAIT)) u_phy (
    .sck       (sck),
    .rst_n     (rst_n),
    .start     (phy_start),
    .half      (phy_half),
    .rw        (rw_q),
    .be        (phy_be),
    .wdat      (phy_wdat),
    .word_addr (addr_q[19:2]),
    .rdat      (phy_rdat),
    .done      (phy_done),
    .sram_addr (sram_addr),
    .sram_data (sram_data),
    .sram_ce_n (sram_ce_n),
    .sram_oe_n (sram_oe_n),
    .sram_we_n (sram_we_n),
    .sram_ub_n (sram_ub_n),
    .sram_lb_n (sram_lb_n)
  );

  // State register.
  always_ff @(posedge sck or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next state. Writes skip any half-word whose byte enables are all 0.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (en) begin
        if (hit_sram) begin
          if (rw && sel == 4'b0000)        state_nx = RESP;
          else if (rw && sel[1:0] == 2'b00) state_nx = SRAM_HI;
          else                              state_nx = SRAM_LO;
        end else if (hit_periph) begin
          state_nx = PERIPH;
        end else begin
          state_nx = RESP;
        end
      end
      SRAM_LO: if (phy_done)
        state_nx = (rw_q && sel_q[3:2] == 2'b00) ? RESP : SRAM_HI;
      SRAM_HI: if (phy_done) state_nx = RESP;
      PERIPH:  if (ack_hit || per_cnt == TO_LAST) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    ready     = 1'b0;
    s_cs_n    = '1;
    phy_start = 1'b0;
    phy_half  = 1'b0;
    case (state)
      SRAM_LO: phy_start = 1'b1;
      SRAM_HI: begin
        phy_start = 1'b1;
        phy_half  = 1'b1;
      end
      PERIPH:  s_cs_n = ~cs_mask;
      RESP:    ready = 1'b1;
      default: ;
    endcase
  end

  // Request latch, response data and peripheral timeout counter.
  // Ack is tested before the timeout so a last-cycle ack still wins.
  always_ff @(posedge sck or negedge rst_n) begin
    if (!rst_n) begin
      rw_q    <= 1'b0;
      sel_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      ch_q    <= '0;
      per_cnt <= '0;
      rdata   <= '0;
      err     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (en) begin
          rw_q    <= rw;
          sel_q   <= sel;
          addr_q  <= addr[19:0];
          wdata_q <= wdata;
          ch_q    <= ch_off[2:0];
          per_cnt <= '0;
          err     <= 1'b0;
          if (!hit_sram && !hit_periph) begin
            err   <= 1'b1;
            rdata <= ERR_RDATA;
          end
        end
        SRAM_LO: if (phy_done && !rw_q) rdata[15:0]  <= phy_rdat;
        SRAM_HI: if (phy_done && !rw_q) rdata[31:16] <= phy_rdat;
        PERIPH: begin
          if (ack_hit) begin
            rdata <= ch_rdata;
          end else if (per_cnt == TO_LAST) begin
            err   <= 1'b1;
            rdata <= ERR_RDATA;
          end else begin
            per_cnt <= per_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign s_rw    = rw_q;
  assign s_sel   = sel_q;
  assign s_addr  = addr_q;
  assign s_wdata = wdata_q;

endmodule

// File: tb/tb_mmio_bus.sv
// tb_mmio_bus: directed plus randomized bench for mmio_bus. A pin-level
// SRAM device and one peripheral (channel 2) respond to the DUT; expected
// data and latencies come from a word-level memory model and the access
// rules (phase count, wait states, timeout).
module tb_mmio_bus;

  localparam int NSLV      = 4;
  localparam int SRAM_WAIT = 0;
  localparam int TIMEOUT   = 16;

  logic                sck = 1'b0;
  logic                rst_n = 1'b0;
  logic                en = 1'b0;
  logic                rw = 1'b0;
  logic [3:0]          sel = '0;
  logic [31:0]         addr = '0;
  logic [31:0]         wdata = '0;
  logic [31:0]         rdata;
  logic                ready, err;
  logic [18:0]         sram_addr;
  wire  [15:0]         sram_data;
  logic                sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;
  logic [NSLV-1:0]     s_cs_n;
  logic                s_rw;
  logic [3:0]          s_sel;
  logic [19:0]         s_addr;
  logic [31:0]         s_wdata;
  logic [32*NSLV-1:0]  s_rdata;
  logic [NSLV-1:0]     s_ack;

  int checks = 0;
  int failures = 0;

  always #5 sck = ~sck;

  mmio_bus #(
    .NSLV(NSLV), .DRAM_REGION(12'h001), .PERIPH_BASE(12'h002),
    .SRAM_WAIT(SRAM_WAIT), .TIMEOUT(TIMEOUT)
  ) dut (
    .sck(sck), .rst_n(rst_n), .en(en), .rw(rw), .sel(sel), .addr(addr),
    .wdata(wdata), .rdata(rdata), .ready(ready), .err(err),
    .sram_addr(sram_addr), .sram_data(sram_data), .sram_ce_n(sram_ce_n),
    .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n), .sram_ub_n(sram_ub_n),
    .sram_lb_n(sram_lb_n), .s_cs_n(s_cs_n), .s_rw(s_rw), .s_sel(s_sel),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_rdata(s_rdata), .s_ack(s_ack)
  );

  // Pin-level async SRAM device (half-word array).
  logic [15:0] dev_mem [0:31];
  always @(posedge sck) begin
    if (!sram_ce_n && !sram_we_n) begin
      if (!sram_lb_n) dev_mem[sram_addr[4:0]][7:0]  <= sram_data[7:0];
      if (!sram_ub_n) dev_mem[sram_addr[4:0]][15:8] <= sram_data[15:8];
    end
  end
  assign sram_data = (!sram_ce_n && !sram_oe_n && sram_we_n) ? dev_mem[sram_addr[4:0]] : 16'bz;

  // Peripheral on channel 2: acks in its 5th selected cycle when enabled.
  // Unselected channels ack permanently and must be ignored.
  int   cs_cycles;
  logic ack_on = 1'b0;
  always @(posedge sck or negedge rst_n) begin
    if (!rst_n)          cs_cycles <= 0;
    else if (!s_cs_n[2]) cs_cycles <= cs_cycles + 1;
    else                 cs_cycles <= 0;
  end
  assign s_ack   = {1'b1, ack_on && (cs_cycles >= 4), 1'b1, 1'b1};
  assign s_rdata = {32'hDEAD_0003, 32'h1234_5678, 32'hDEAD_0001, 32'hDEAD_0000};

  // Word-level reference memory.
  logic [31:0] ref_mem [0:15];

  function automatic logic [31:0] merge(input logic [31:0] old_w, new_w, input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  function automatic int sram_cycles(input logic t_rw, input logic [3:0] t_sel);
    int phases;
    phases = t_rw ? (int'(|t_sel[1:0]) + int'(|t_sel[3:2])) : 2;
    return phases * (SRAM_WAIT + 1) + 1;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Per-transaction observations.
  logic [31:0] got_rdata;
  logic        got_err;
  int          got_cycles;
  logic [18:0] we_addr [$];
  logic [15:0] we_data [$];
  logic [1:0]  we_bn   [$];
  int          oe_cycles, ce_cycles, cs_low_cycles, cs_2_cycles;
  logic [NSLV-1:0] cs_at_ready;

  task automatic run_txn(input logic t_rw, input logic [3:0] t_sel,
                         input logic [31:0] t_addr, input logic [31:0] t_wdata);
    we_addr.delete(); we_data.delete(); we_bn.delete();
    oe_cycles = 0; ce_cycles = 0; cs_low_cycles = 0; cs_2_cycles = 0;
    got_cycles = -1; got_rdata = 'x; got_err = 1'bx; cs_at_ready = 'x;
    @(negedge sck);
    en = 1'b1; rw = t_rw; sel = t_sel; addr = t_addr; wdata = t_wdata;
    @(posedge sck);
    #1 en = 1'b0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge sck);
      if (ready) begin
        got_cycles  = i;
        got_rdata   = rdata;
        got_err     = err;
        cs_at_ready = s_cs_n;
        break;
      end
      if (!sram_we_n) begin
        we_addr.push_back(sram_addr);
        we_data.push_back(sram_data);
        we_bn.push_back({sram_ub_n, sram_lb_n});
      end
      if (!sram_oe_n) oe_cycles++;
      if (!sram_ce_n) ce_cycles++;
      if (s_cs_n != '1) cs_low_cycles++;
      if (s_cs_n == 4'b1011) cs_2_cycles++;
    end
  endtask

  logic        r_rw;
  logic [3:0]  r_sel;
  logic [31:0] r_addr, r_wdata;
  int          r_idx;
  logic        seen_ready;

  initial begin
    for (int i = 0; i < 32; i++) dev_mem[i] = '0;
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;

    // Reset state.
    repeat (2) @(negedge sck);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_sram_ctl", 32'({sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}), 32'h1F);
    check("rst_cs_n", 32'(s_cs_n), 32'hF);
    rst_n = 1'b1;

    // Full-word SRAM write.
    run_txn(1'b1, 4'hF, 32'h0010_0008, 32'hCAFE_F00D);
    ref_mem[2] = merge(ref_mem[2], 32'hCAFE_F00D, 4'hF);
    check("wr_cycles", 32'(got_cycles), 32'(sram_cycles(1'b1, 4'hF)));
    check("wr_err", 32'(got_err), 32'd0);
    check("wr_we_count", 32'(we_addr.size()), 32'd2);
    check("wr_lo_addr", 32'(we_addr[0]), 32'h4);
    check("wr_lo_data", 32'(we_data[0]), 32'hF00D);
    check("wr_hi_addr", 32'(we_addr[1]), 32'h5);
    check("wr_hi_data", 32'(we_data[1]), 32'hCAFE);
    check("wr_bn", 32'({we_bn[0], we_bn[1]}), 32'h0);

    // Read back.
    run_txn(1'b0, 4'hF, 32'h0010_0008, 32'h0);
    check("rd_cycles", 32'(got_cycles), 32'(sram_cycles(1'b0, 4'hF)));
    check("rd_data", got_rdata, ref_mem[2]);
    check("rd_err", 32'(got_err), 32'd0);
    check("rd_oe_cycles", 32'(oe_cycles), 32'(2 * (SRAM_WAIT + 1)));
    check("rd_no_we", 32'(we_addr.size()), 32'd0);

    // Single-byte write in the high half-word only.
    run_txn(1'b1, 4'b0100, 32'h0010_0008, 32'h00AB_0000);
    ref_mem[2] = merge(ref_mem[2], 32'h00AB_0000, 4'b0100);
    check("bw_cycles", 32'(got_cycles), 32'(sram_cycles(1'b1, 4'b0100)));
    check("bw_we_count", 32'(we_addr.size()), 32'd1);
    check("bw_addr", 32'(we_addr[0]), 32'h5);
    check("bw_data", 32'(we_data[0]), 32'h00AB);
    check("bw_ub_lb", 32'(we_bn[0]), 32'b10);
    run_txn(1'b0, 4'hF, 32'h0010_0008, 32'h0);
    check("bw_readback", got_rdata, ref_mem[2]);

    // Write with no byte enables: no SRAM activity, immediate response.
    run_txn(1'b1, 4'h0, 32'h0010_000C, 32'hFFFF_FFFF);
    check("sel0_cycles", 32'(got_cycles), 32'd1);
    check("sel0_ce", 32'(ce_cycles), 32'd0);

    // Peripheral channel 2 with ack after 5 selected cycles.
    ack_on = 1'b1;
    run_txn(1'b0, 4'hF, 32'h0040_0ABC, 32'h5555_AAAA);
    check("per_cycles", 32'(got_cycles), 32'd6);
    check("per_rdata", got_rdata, 32'h1234_5678);
    check("per_err", 32'(got_err), 32'd0);
    check("per_cs_sel", 32'(cs_2_cycles), 32'd5);
    check("per_cs_any", 32'(cs_low_cycles), 32'd5);
    check("per_cs_resp", 32'(cs_at_ready), 32'hF);
    check("per_s_addr", 32'(s_addr), 32'h00ABC);
    check("per_s_wdata", s_wdata, 32'h5555_AAAA);

    // Same channel, never acks: timeout.
    ack_on = 1'b0;
    run_txn(1'b0, 4'hF, 32'h0040_0000, 32'h0);
    check("to_cycles", 32'(got_cycles), 32'(TIMEOUT + 1));
    check("to_err", 32'(got_err), 32'd1);
    check("to_rdata", got_rdata, 32'h0);

    // Unmapped region.
    run_txn(1'b0, 4'hF, 32'h0F00_0000, 32'h0);
    check("um_cycles", 32'(got_cycles), 32'd1);
    check("um_err", 32'(got_err), 32'd1);
    check("um_rdata", got_rdata, 32'h0);
    check("um_activity", 32'(ce_cycles + cs_low_cycles), 32'd0);

    // Reset during the high phase of a write.
    @(negedge sck);
    en = 1'b1; rw = 1'b1; sel = 4'hF; addr = 32'h0010_0010; wdata = 32'h1111_2222;
    @(posedge sck);
    #1 en = 1'b0;
    @(posedge sck);
    #1;
    check("mid_hi_addr", 32'(sram_addr), 32'h9);
    check("mid_hi_we", 32'(sram_we_n), 32'd0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_pins", 32'({sram_ce_n, sram_oe_n, sram_we_n}), 32'h7);
    check("mid_rst_ready", 32'(ready), 32'd0);
    ref_mem[4] = merge(ref_mem[4], 32'h1111_2222, 4'b0011);
    repeat (2) @(negedge sck);
    rst_n = 1'b1;
    seen_ready = 1'b0;
    repeat (3) begin
      @(negedge sck);
      seen_ready |= ready;
    end
    check("mid_no_ready", 32'(seen_ready), 32'd0);
    check("mid_rdata_clr", rdata, 32'h0);
    run_txn(1'b0, 4'hF, 32'h0010_0010, 32'h0);
    check("mid_readback", got_rdata, ref_mem[4]);
    check("mid_rb_cycles", 32'(got_cycles), 32'(sram_cycles(1'b0, 4'hF)));

    // Randomized SRAM traffic with occasional unmapped accesses.
    for (int n = 0; n < 40; n++) begin
      r_idx   = int'($urandom_range(0, 15));
      r_rw    = 1'($urandom_range(0, 1));
      r_sel   = 4'($urandom);
      r_wdata = $urandom;
      if ($urandom_range(0, 7) == 0) begin
        r_addr = {12'h0F0 + 12'($urandom_range(0, 15)), 20'($urandom)};
        run_txn(r_rw, r_sel, r_addr, r_wdata);
        check("rnd_um_cycles", 32'(got_cycles), 32'd1);
        check("rnd_um_err", 32'(got_err), 32'd1);
        check("rnd_um_rdata", got_rdata, 32'h0);
      end else begin
        r_addr = 32'h0010_0000 | (32'(r_idx) << 2);
        run_txn(r_rw, r_sel, r_addr, r_wdata);
        check("rnd_cycles", 32'(got_cycles), 32'(sram_cycles(r_rw, r_sel)));
        check("rnd_err", 32'(got_err), 32'd0);
        if (r_rw) ref_mem[r_idx] = merge(ref_mem[r_idx], r_wdata, r_sel);
        else      check("rnd_rdata", got_rdata, ref_mem[r_idx]);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mmio_bus.md
Name: mmio_bus

Overview:
- Parametrised successor to the single-master system bus.
- Decodes CPU accesses by addr[31:20] region into one 16-bit async SRAM window and NSLV generic peripheral channels.
- Sequences 32-bit SRAM accesses as two 16-bit phases with configurable wait states; peripherals use a cs/ack handshake with timeout.
- Returns a one-cycle ready pulse plus an error flag, replacing the old free-running two-phase toggle.

Parameters:
- NSLV, 4: number of peripheral channels (1..8).
- DRAM_REGION, 12'h001: addr[31:20] value selecting SRAM.
- PERIPH_BASE, 12'h002: region of channel 0; channel i is PERIPH_BASE+i.
- SRAM_WAIT, 0: extra cycles per SRAM half-word phase (0..7).
- TIMEOUT, 255: peripheral cycles without ack before error (1..65535).

Ports:
- sck  in  1  clock; all logic on posedge.
- rst_n  in  1  reset; asynchronous, active-low.
- en  in  1  request valid; sampled only in IDLE.
- rw  in  1  1=write, 0=read.
- sel  in  4  byte enables; sel[0]=wdata[7:0].
- addr  in  32  byte address.
- wdata  in  32  write data.
- rdata  out  32  read data, valid while ready=1.
- ready  out  1  one-cycle completion pulse.
- err  out  1  error qualifier, valid with ready.
- sram_addr  out  19  half-word address {addr[19:2],phase}.
- sram_data  inout  16  driven only during write phases, else Z.
- sram_ce_n  out  1  SRAM chip enable, active-low.
- sram_oe_n  out  1  SRAM output enable, active-low.
- sram_we_n  out  1  SRAM write enable, active-low.
- sram_ub_n  out  1  SRAM upper byte enable, active-low.
- sram_lb_n  out  1  SRAM lower byte enable, active-low.
- s_cs_n  out  NSLV  per-channel select, active-low.
- s_rw  out  1  latched rw, shared.
- s_sel  out  4  latched sel, shared.
- s_addr  out  20  latched addr[19:0], shared.
- s_wdata  out  32  latched wdata, shared.
- s_rdata  in  32*NSLV  channel i read data on bits [32i+31:32i].
- s_ack  in  NSLV  per-channel completion, level sampled.

Behaviour:
- Reset (rst_n=0, async, immediate):
  - state=IDLE, ready=0, err=0, rdata=0.
  - sram_ce_n/oe_n/we_n/ub_n/lb_n=1, sram_data=Z.
  - s_cs_n all 1, latched request regs cleared.
  - Reset mid-transaction aborts it; no ready is produced.
- FSM states: IDLE, SRAM_LO, SRAM_HI, PERIPH, RESP.
- IDLE, en=1 at posedge: latch rw/sel/addr/wdata, then decode:
  - region==DRAM_REGION -> SRAM_LO.
  - PERIPH_BASE <= region < PERIPH_BASE+NSLV -> PERIPH.
  - otherwise -> RESP with err=1, rdata=0.
- SRAM phases:
  - Each phase lasts SRAM_WAIT+1 cycles, using a 3-bit counter cleared on phase entry.
  - LO uses sram_addr lsb=0 and wdata[15:0]; HI uses lsb=1 and wdata[31:16].
  - ce_n=0 throughout the phase.
  - Read: oe_n=0, ub_n=lb_n=0. sram_data is sampled on the last cycle of the phase into rdata[15:0] (LO) or rdata[31:16] (HI).
  - Write: oe_n=1, data driven for the whole phase. we_n=0 for the first max(SRAM_WAIT,1) cycles of the phase. lb_n=~sel[0]/~sel[2] and ub_n=~sel[1]/~sel[3] for LO/HI respectively.
  - A write phase whose two sel bits are both 0 is skipped (0 cycles). A write with sel=0 goes straight to RESP.
  - Reads always run both phases.
- PERIPH:
  - s_cs_n[i]=0 for the decoded channel only.
  - On s_ack[i]=1 at posedge: capture s_rdata slice i into rdata -> RESP, err=0.
  - A cycle counter reaching TIMEOUT without ack -> RESP, err=1, rdata=0.
  - s_cs_n returns to 1 in RESP.
- RESP: ready=1 for exactly one cycle, then -> IDLE. en during RESP is ignored; a held en starts a new transaction in the next IDLE cycle.
- rdata holds its last value until the next capture; err is cleared on the next accept.
- Latency (accept edge = E; ready high in the cycle after the listed edge):
  - SRAM read, SRAM_WAIT=0: ready after E+2 edges, i.e. 3 cycles after accept.
  - General SRAM read: 2*(SRAM_WAIT+1)+1 cycles.
  - Unmapped: 1 cycle.
- Simultaneous acks on unselected channels are ignored.
- An ack arriving in the same cycle the counter hits TIMEOUT wins: data is captured, err=0.

Decomposition:
- Package mmio_bus_pkg:
  - FSM state enum.
  - Region width constant (12).
  - Phase-counter width.
  - Error rdata constant (32'h0).
- Sub-module sram16_phy:
  - Holds the phase counter and pin driving (ce/oe/we/ub/lb, tristate).
  - Interface: start, half, rw, be[1:0], wdat[15:0], rdat[15:0], done.
- Decode and FSM stay in mmio_bus.

Test Plan:
- SRAM write 32'hCAFE_F00D, sel=4'hF, addr 32'h0010_0008, SRAM_WAIT=0: sram_addr 19'h4 then 19'h5 carry 16'hF00D then 16'hCAFE, one we_n pulse each; ready 3 cycles after accept, err=0.
- Read back from the same address via SRAM model: rdata=32'hCAFE_F00D with ready; oe_n=0 in both phases; sram_data never driven by DUT.
- Byte write sel=4'b0100, wdata=32'h00AB_0000: only HI phase runs, lb_n=0, ub_n=1, data 16'h00AB; ready 2 cycles after accept.
- Peripheral channel 2 (addr 32'h0040_0000), ack after 5 cycles with s_rdata slice 32'h1234_5678: s_cs_n=4'b1011 until ack, rdata=32'h1234_5678, err=0. Repeat with no ack: ready with err=1 after TIMEOUT cycles.
- Unmapped addr 32'h0F00_0000: ready next cycle, err=1, rdata=0, no SRAM or s_cs_n activity.
- rst_n asserted mid SRAM_HI write: we_n/ce_n go 1 and sram_data goes Z immediately, no ready; a subsequent read transaction completes normally.
